// File: rtl/s_pea_cfg_sequencer.sv
// PE array configuration sequencer: shadow-bank load, atomic commit, run gating and drain-to-NOP.
// Optional macro S_PEA_CFG_SEQ_DBL_BUF_EN lets the next bank load while the array runs.
module s_pea_cfg_sequencer #(
   parameter int unsigned N_PE         = 16,
   parameter int unsigned CFG_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_valid_i,
   output logic                    cfg_ready_o,
   input  logic [CFG_W-1:0]        cfg_data_i,
   input  logic                    cfg_last_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic [N_PE-1:0]         pea_valid_i,
   output logic [N_PE*CFG_W-1:0]   ctrl_pe_o,
   output logic                    pea_ready_o,
   output logic                    busy_o,
   output logic                    cfg_err_o
);

   localparam int unsigned IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
   localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DRAIN_CYCLES);

`ifdef S_PEA_CFG_SEQ_DBL_BUF_EN
   localparam logic DBL_BUF = 1'b1;
`else
   localparam logic DBL_BUF = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARMED,
      S_RUN,
      S_DRAIN
   } state_e;

   state_e                        state_q;
   logic [IDX_W-1:0]              wr_idx_q, wr_idx_d;
   logic [CNT_W-1:0]              drain_cnt_q;
   logic                          shadow_valid_q, shadow_valid_d;
   logic [N_PE-1:0][CFG_W-1:0]    shadow_q;
   logic [N_PE*CFG_W-1:0]         ctrl_q;
   logic                          cfg_ready_q;
   logic                          pea_ready_q;
   logic                          busy_q;
   logic                          cfg_err_q;

   logic cfg_fire_c;
   logic at_end_c;
   logic bank_done_d;
   logic bank_err_d;
   logic run_ready_c;
   logic drain_exit_c;
   logic drain_to_armed_c;

   assign cfg_fire_c = cfg_valid_i & cfg_ready_q;
   assign at_end_c   = (wr_idx_q == IDX_LAST);

   // Bank-length bookkeeping shared by the idle load path and the run-time load path.
   always_comb begin
      wr_idx_d       = wr_idx_q;
      bank_done_d    = 1'b0;
      bank_err_d     = 1'b0;
      shadow_valid_d = shadow_valid_q;
      if (cfg_fire_c) begin
         if (at_end_c && cfg_last_i) begin
            bank_done_d    = 1'b1;
            wr_idx_d       = '0;
            shadow_valid_d = 1'b1;
         end else if (at_end_c || cfg_last_i) begin
            bank_err_d     = 1'b1;
            wr_idx_d       = '0;
            shadow_valid_d = 1'b0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end
   end

   assign run_ready_c      = DBL_BUF & ~shadow_valid_d;
   assign drain_to_armed_c = DBL_BUF & shadow_valid_d;
   assign drain_exit_c     = (pea_valid_i == '0) || (drain_cnt_q == CNT_LAST);

   // Shadow bank storage; contents are only meaningful once shadow_valid is set.
   always_ff @(posedge clk_i) begin
      if (cfg_fire_c) begin
         shadow_q[wr_idx_q] <= cfg_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         wr_idx_q       <= '0;
         drain_cnt_q    <= '0;
         shadow_valid_q <= 1'b0;
         ctrl_q         <= '0;
         cfg_ready_q    <= 1'b0;
         pea_ready_q    <= 1'b0;
         busy_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         wr_idx_q <= wr_idx_d;
         if (bank_err_d) begin
            cfg_err_q <= 1'b1;
         end
         case (state_q)
            S_IDLE, S_LOAD: begin
               if (bank_done_d) begin
                  state_q        <= S_ARMED;
                  shadow_valid_q <= 1'b1;
                  cfg_ready_q    <= 1'b0;
               end else if (bank_err_d) begin
                  state_q        <= S_IDLE;
                  shadow_valid_q <= 1'b0;
                  cfg_ready_q    <= 1'b1;
               end else begin
                  if (cfg_fire_c) begin
                     state_q <= S_LOAD;
                  end
                  cfg_ready_q <= 1'b1;
               end
            end
            S_ARMED: begin
               // Stop has priority over a simultaneous start.
               if (stop_i) begin
                  state_q        <= S_IDLE;
                  shadow_valid_q <= 1'b0;
                  cfg_ready_q    <= 1'b1;
               end else if (start_i) begin
                  state_q        <= S_RUN;
                  shadow_valid_q <= 1'b0;
                  ctrl_q         <= shadow_q;
                  pea_ready_q    <= 1'b1;
                  busy_q         <= 1'b1;
                  cfg_ready_q    <= DBL_BUF;
               end
            end
            S_RUN: begin
               shadow_valid_q <= shadow_valid_d;
               cfg_ready_q    <= run_ready_c;
               if (stop_i) begin
                  state_q     <= S_DRAIN;
                  drain_cnt_q <= '0;
               end
            end
            S_DRAIN: begin
               shadow_valid_q <= shadow_valid_d;
               if (drain_exit_c) begin
                  ctrl_q      <= '0;
                  pea_ready_q <= 1'b0;
                  busy_q      <= 1'b0;
                  if (drain_to_armed_c) begin
                     state_q     <= S_ARMED;
                     cfg_ready_q <= 1'b0;
                  end else begin
                     state_q     <= S_IDLE;
                     cfg_ready_q <= 1'b1;
                  end
               end else begin
                  if (drain_cnt_q != CNT_SAT) begin
                     drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                  end
                  cfg_ready_q <= run_ready_c;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready_o = cfg_ready_q;
   assign ctrl_pe_o   = ctrl_q;
   assign pea_ready_o = pea_ready_q;
   assign busy_o      = busy_q;
   assign cfg_err_o   = cfg_err_q;

endmodule
